// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment bit positions, digit glyphs, decoder FSM states
// and the glyph <-> digit conversion helpers used by the driver and the decoder.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_ERR   = 8'h79;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_PRESENT = 2'd2
  } seg_state_e;

  typedef struct packed {
    logic [3:0] digit;
    logic       err;
  } seg_dec_t;

  // The "E" glyph is a legitimate driver output, so it decodes cleanly with err=0.
  function automatic seg_dec_t seg_decode(input logic [6:0] glyph);
    seg_dec_t d;
    d.digit = 4'hF;
    d.err   = 1'b0;
    case (glyph)
      SEG_0[6:0]:   d.digit = 4'd0;
      SEG_1[6:0]:   d.digit = 4'd1;
      SEG_2[6:0]:   d.digit = 4'd2;
      SEG_3[6:0]:   d.digit = 4'd3;
      SEG_4[6:0]:   d.digit = 4'd4;
      SEG_5[6:0]:   d.digit = 4'd5;
      SEG_6[6:0]:   d.digit = 4'd6;
      SEG_7[6:0]:   d.digit = 4'd7;
      SEG_8[6:0]:   d.digit = 4'd8;
      SEG_9[6:0]:   d.digit = 4'd9;
      SEG_ERR[6:0]: d.digit = 4'hE;
      default: begin
        d.digit = 4'hF;
        d.err   = 1'b1;
      end
    endcase
    return d;
  endfunction

  function automatic logic [7:0] seg_encode(input logic [3:0] digit, input logic dp);
    logic [7:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_ERR;
    endcase
    pat[SEG_DP] = dp;
    return pat;
  endfunction

endpackage

// File: rtl/seg_sync2.sv
// Two-flop synchronizer for asynchronous pad inputs; cleared by the synchronous reset.
module seg_sync2 #(
  parameter int DATA_W = 8
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta_p0;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/segment_decoder.sv
// Reads a 7-segment bus back as numbers: synchronizes it, waits for a stable new pattern,
// decodes it and holds the result on a valid/ready port until the consumer takes it.
module segment_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [7:0]       seg_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3:0]       digit_out,
  output logic             dp_out,
  output logic             err_out,
  output logic             overrun,
  output logic [CNT_W-1:0] evt_count
);

  localparam logic [7:0] STAB_TGT = 8'(STABLE_CYCLES);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0]       seg_s;
  seg_state_e       state, state_nxt;
  logic [7:0]       cand, cand_nxt;
  logic [7:0]       stab_cnt, stab_nxt;
  logic [7:0]       last_pat, last_nxt;
  logic             valid_nxt, dp_nxt, err_nxt, ovr_nxt;
  logic [3:0]       digit_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [6:0]       cand_glyph;
  seg_dec_t         cand_dec;
  logic             accept;

  // Stage 0 -> 1: pad synchronization; nothing else touches seg_in
  seg_sync2 #(.DATA_W(8)) u_sync (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .d       (seg_in),
    .q       (seg_s)
  );

  assign cand_glyph = {cand[SEG_G], cand[SEG_F], cand[SEG_E], cand[SEG_D],
                       cand[SEG_C], cand[SEG_B], cand[SEG_A]};
  assign cand_dec   = seg_decode(cand_glyph);
  assign accept     = out_valid && out_ready;

  // Stage 1 -> 2: qualification FSM and output register
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    stab_nxt  = stab_cnt;
    last_nxt  = last_pat;
    valid_nxt = out_valid;
    digit_nxt = digit_out;
    dp_nxt    = dp_out;
    err_nxt   = err_out;
    ovr_nxt   = overrun;
    cnt_nxt   = evt_count;
    case (state)
      ST_IDLE: begin
        if (seg_s != last_pat) begin
          cand_nxt  = seg_s;
          stab_nxt  = 8'd1;
          state_nxt = ST_QUALIFY;
        end
      end
      ST_QUALIFY: begin
        // Once the count is reached the candidate is committed even if seg_s moves now.
        if (stab_cnt >= STAB_TGT) begin
          last_nxt = cand;
          if (cand != SEG_BLANK) begin
            valid_nxt = 1'b1;
            digit_nxt = cand_dec.digit;
            dp_nxt    = cand[SEG_DP];
            err_nxt   = cand_dec.err;
            state_nxt = ST_PRESENT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (seg_s != cand) begin
          if (seg_s == last_pat) begin
            state_nxt = ST_IDLE;
          end else begin
            cand_nxt = seg_s;
            stab_nxt = 8'd1;
          end
        end else begin
          stab_nxt = sat_inc(stab_cnt);
        end
      end
      ST_PRESENT: begin
        // Keep tracking the bus so a stable newer pattern can be flagged as lost.
        if (seg_s != cand) begin
          cand_nxt = seg_s;
          stab_nxt = 8'd1;
        end else begin
          stab_nxt = sat_inc(stab_cnt);
        end
        if (accept) begin
          valid_nxt = 1'b0;
          cnt_nxt   = evt_count + CNT_W'(1);
          state_nxt = ST_IDLE;
        end else if ((cand != last_pat) && (stab_cnt >= STAB_TGT)) begin
          ovr_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      cand      <= 8'h00;
      stab_cnt  <= 8'h00;
      last_pat  <= 8'h00;
      out_valid <= 1'b0;
      digit_out <= 4'h0;
      dp_out    <= 1'b0;
      err_out   <= 1'b0;
      overrun   <= 1'b0;
      evt_count <= '0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      stab_cnt  <= stab_nxt;
      last_pat  <= last_nxt;
      out_valid <= valid_nxt;
      digit_out <= digit_nxt;
      dp_out    <= dp_nxt;
      err_out   <= err_nxt;
      overrun   <= ovr_nxt;
      evt_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_segment_decoder.sv
// Bench for segment_decoder: directed table, hand-written corner sequences and a random
// phase scored against a pattern-level reference model.
module tb_segment_decoder;

  localparam int SC = 4;
  localparam int CW = 8;

  logic          CLOCK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [7:0]    seg_in = 8'h00;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [3:0]    digit_out;
  logic          dp_out;
  logic          err_out;
  logic          overrun;
  logic [CW-1:0] evt_count;

  segment_decoder #(.STABLE_CYCLES(SC), .CNT_W(CW)) dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .seg_in    (seg_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .digit_out (digit_out),
    .dp_out    (dp_out),
    .err_out   (err_out),
    .overrun   (overrun),
    .evt_count (evt_count)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [7:0] pat;
    logic       ev;
    logic [3:0] dig;
    logic       dp;
    logic       err;
  } vec_t;

  typedef struct packed {
    logic [3:0] dig;
    logic       dp;
    logic       err;
  } evt_t;

  logic [7:0] glyph [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                             8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;
  vec_t tbl[$];
  evt_t exp_q[$];

  function automatic evt_t ref_event(input logic [7:0] pat);
    evt_t e;
    e.dp  = pat[7];
    e.dig = 4'hF;
    e.err = 1'b1;
    for (int i = 0; i < 10; i++)
      if (pat[6:0] == glyph[i][6:0]) begin
        e.dig = 4'(i);
        e.err = 1'b0;
      end
    if (pat[6:0] == 7'h79) begin
      e.dig = 4'hE;
      e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int i;
    i = 0;
    while (!out_valid && i < budget) begin
      tick(1);
      i++;
    end
    check(name, 32'(out_valid), 32'd1);
  endtask

  task automatic take_event();
    evt_t e;
    exp_cnt++;
    check("rand_event_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rand_digit", 32'(digit_out), 32'(e.dig));
      check("rand_dp", 32'(dp_out), 32'(e.dp));
      check("rand_err", 32'(err_out), 32'(e.err));
    end
  endtask

  task automatic hold_mon(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (out_valid && out_ready) take_event();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p;
    logic [7:0] prev;
    logic [7:0] model_last;
    logic [7:0] v;
    int         nev;
    logic [3:0] dlast;

    // Reset state
    tick(3);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_digit", 32'(digit_out), 32'd0);
    check("reset_dp", 32'(dp_out), 32'd0);
    check("reset_err", 32'(err_out), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_evt_count", 32'(evt_count), 32'd0);
    RESET_N = 1'b1;
    out_ready = 1'b1;
    tick(2);

    // Latency: valid appears exactly after edge k+2+SC
    seg_in = 8'h06;
    tick(1 + SC + 1);
    check("t1_not_early", 32'(out_valid), 32'd0);
    tick(1);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_digit", 32'(digit_out), 32'd1);
    check("t1_err", 32'(err_out), 32'd0);
    check("t1_dp", 32'(dp_out), 32'd0);
    tick(1);
    exp_cnt++;
    check("t1_accepted", 32'(out_valid), 32'd0);
    check("t1_evt_count", 32'(evt_count), 32'(exp_cnt));

    // Table: 0..9 with alternating dp, then E glyph, errors, blank, and a following zero
    for (int i = 0; i < 10; i++) begin
      p = glyph[i];
      p[7] = i[0];
      tbl.push_back('{p, 1'b1, 4'(i), i[0], 1'b0});
    end
    tbl.push_back('{8'h79, 1'b1, 4'hE, 1'b0, 1'b0});
    tbl.push_back('{8'h55, 1'b1, 4'hF, 1'b0, 1'b1});
    tbl.push_back('{8'hD5, 1'b1, 4'hF, 1'b1, 1'b1});
    tbl.push_back('{8'h00, 1'b0, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{8'h3F, 1'b1, 4'h0, 1'b0, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      seg_in = tbl[i].pat;
      if (tbl[i].ev) begin
        wait_valid($sformatf("tbl%0d_valid", i), 20);
        check($sformatf("tbl%0d_digit", i), 32'(digit_out), 32'(tbl[i].dig));
        check($sformatf("tbl%0d_dp", i), 32'(dp_out), 32'(tbl[i].dp));
        check($sformatf("tbl%0d_err", i), 32'(err_out), 32'(tbl[i].err));
        tick(1);
        exp_cnt++;
      end else begin
        nev = 0;
        for (int c = 0; c < 12; c++) begin
          tick(1);
          if (out_valid) nev++;
        end
        check($sformatf("tbl%0d_blank_silent", i), 32'(nev), 32'd0);
      end
    end
    check("tbl_evt_count", 32'(evt_count), 32'(exp_cnt[CW-1:0]));

    // Glitch through 8 must not report; only the settled 9 does
    seg_in = 8'h7F;
    tick(2);
    seg_in = 8'h6F;
    nev = 0;
    dlast = 4'h0;
    for (int c = 0; c < 25; c++) begin
      tick(1);
      if (out_valid && out_ready) begin
        nev++;
        dlast = digit_out;
      end
    end
    exp_cnt += nev;
    check("t3_one_event", 32'(nev), 32'd1);
    check("t3_digit", 32'(dlast), 32'd9);

    // Overrun while a 3 is pending, then the 2 is requalified after acceptance
    out_ready = 1'b0;
    seg_in = 8'h4F;
    wait_valid("t4_valid3", 20);
    check("t4_digit3", 32'(digit_out), 32'd3);
    seg_in = 8'h5B;
    tick(10);
    check("t4_still_valid", 32'(out_valid), 32'd1);
    check("t4_frozen_digit", 32'(digit_out), 32'd3);
    check("t4_overrun", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    tick(1);
    exp_cnt++;
    check("t4_accepted", 32'(out_valid), 32'd0);
    wait_valid("t4_valid2", 20);
    check("t4_digit2", 32'(digit_out), 32'd2);
    tick(1);
    exp_cnt++;
    check("t4_overrun_sticky", 32'(overrun), 32'd1);
    check("t4_evt_count", 32'(evt_count), 32'(exp_cnt[CW-1:0]));

    // Reset during PRESENT clears everything, including last_pat
    out_ready = 1'b0;
    seg_in = 8'h66;
    wait_valid("t6_valid", 20);
    RESET_N = 1'b0;
    tick(1);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_digit", 32'(digit_out), 32'd0);
    check("t6_dp", 32'(dp_out), 32'd0);
    check("t6_err", 32'(err_out), 32'd0);
    check("t6_overrun", 32'(overrun), 32'd0);
    check("t6_evt_count", 32'(evt_count), 32'd0);
    exp_cnt = 0;
    RESET_N = 1'b1;
    out_ready = 1'b1;
    wait_valid("t6_rereport", 20);
    check("t6_digit_again", 32'(digit_out), 32'd4);
    tick(1);
    exp_cnt++;
    check("t6_evt_count_after", 32'(evt_count), 32'd1);

    // Random patterns: short glitches never qualify, long holds qualify if they differ
    prev = 8'h66;
    model_last = 8'h66;
    for (int s = 0; s < 400; s++) begin
      int  idx;
      int  r;
      bit  is_short;
      int  dur;
      do begin
        r = $urandom_range(0, 9);
        if (r < 6) begin
          idx = $urandom_range(0, 10);
          v = (idx == 10) ? 8'h79 : glyph[idx];
          v[7] = 1'($urandom_range(0, 1));
        end else if (r < 9) begin
          v = 8'($urandom);
        end else begin
          v = 8'h00;
        end
      end while (v == prev);
      is_short = (s != 399) && ($urandom_range(0, 3) == 0);
      dur = is_short ? $urandom_range(1, 2) : $urandom_range(10, 14);
      if (!is_short && v != model_last) begin
        if (v != 8'h00) exp_q.push_back(ref_event(v));
        model_last = v;
      end
      seg_in = v;
      hold_mon(dur);
      prev = v;
    end
    hold_mon(20);
    check("rand_all_events_seen", 32'(exp_q.size()), 32'd0);
    check("rand_evt_count_wrap", 32'(evt_count), 32'(exp_cnt[CW-1:0]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
